// File: rtl/move_controller_if.sv
// move_controller_if: the cursor/click inputs and the chess_board pick/place bus of the move controller.
// The master modport is the controller side; the slave modport is the board/cursor side.
interface move_controller_if;
    logic        click;
    logic [5:0]  cursor_pos;
    logic        cursor_valid;
    logic [3:0]  sq_code;
    logic [63:0] possible_moves;
    logic        pick_piece;
    logic        place_piece;
    logic [5:0]  figure_position;
    logic [5:0]  from_pos;
    logic        holding;
    logic        turn;
    logic        move_done;
    logic        game_over;
    logic        winner;

    modport master (
        input  click, cursor_pos, cursor_valid, sq_code, possible_moves,
        output pick_piece, place_piece, figure_position, from_pos, holding,
               turn, move_done, game_over, winner
    );

    modport slave (
        output click, cursor_pos, cursor_valid, sq_code, possible_moves,
        input  pick_piece, place_piece, figure_position, from_pos, holding,
               turn, move_done, game_over, winner
    );
endinterface

// File: rtl/move_controller.sv
// move_controller: initiator side of the chess_board pick/place interface.
// Debounces the mouse click, turns accepted clicks into single-cycle pick/place commands,
// enforces turn order, piece colour and the legal-move mask, and detects king capture.
// Optional feature macro: AUTO_RETURN_EN -- a held piece is put back on its origin square
// after HOLD_TIMEOUT cycles without a placing click.
module move_controller #(
    parameter int DEBOUNCE_CYCLES = 650_000,
    parameter int HOLD_TIMEOUT    = 325_000_000
) (
    input  logic              clk,
    input  logic              rst_n,
    move_controller_if.master bus
);

    // Reject configurations that cannot work (a zero debounce or timeout window).
    if (DEBOUNCE_CYCLES < 1 || HOLD_TIMEOUT < 1) begin : g_bad_params
        $error("move_controller: DEBOUNCE_CYCLES and HOLD_TIMEOUT must be >= 1");
    end

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PICK  = 3'd1,
        S_HOLD  = 3'd2,
        S_PLACE = 3'd3,
        S_RET   = 3'd4,
        S_OVER  = 3'd5
    } state_t;

    // Board codes: 0 empty, 1-6 white (6 king), 7-12 black (12 king), 13 highlight (empty).
    function automatic logic is_white(input logic [3:0] code);
        return (code >= 4'd1) && (code <= 4'd6);
    endfunction

    function automatic logic is_black(input logic [3:0] code);
        return (code >= 4'd7) && (code <= 4'd12);
    endfunction

    function automatic logic is_own(input logic [3:0] code, input logic side);
        return side ? is_black(code) : is_white(code);
    endfunction

    function automatic logic [3:0] opponent_king(input logic side);
        return side ? 4'd6 : 4'd12;
    endfunction

    logic [1:0]      sync_r;
    logic            click_s;
    logic [DB_W-1:0] db_cnt_r;
    logic            filt_r;
    logic            filt_d_r;
    logic            event_s;

    state_t          state_r;
    logic            pick_r;
    logic            place_r;
    logic [5:0]      fig_pos_r;
    logic [5:0]      from_pos_r;
    logic            holding_r;
    logic            turn_r;
    logic            move_done_r;
    logic            game_over_r;
    logic            winner_r;
    logic            capture_king_r;

    logic            legal_s;
    logic            timeout_s;

    // Two-flop synchroniser for the asynchronous mouse button.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_r <= 2'b00;
        end else begin
            sync_r <= {sync_r[0], bus.click};
        end
    end

    assign click_s = sync_r[1];

    // Debounce filter: the filtered level follows only after DEBOUNCE_CYCLES stable cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db_cnt_r <= {DB_W{1'b0}};
            filt_r   <= 1'b0;
            filt_d_r <= 1'b0;
        end else begin
            filt_d_r <= filt_r;
            if (click_s == filt_r) begin
                db_cnt_r <= {DB_W{1'b0}};
            end else if (db_cnt_r == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                filt_r   <= click_s;
                db_cnt_r <= {DB_W{1'b0}};
            end else begin
                db_cnt_r <= db_cnt_r + DB_W'(1);
            end
        end
    end

    // A click event is the single cycle where the filtered level rises.
    assign event_s = filt_r & ~filt_d_r;

    assign legal_s = bus.possible_moves[6'd63 - bus.cursor_pos];

`ifdef AUTO_RETURN_EN
    localparam int HT_W = $clog2(HOLD_TIMEOUT + 1);
    logic [HT_W-1:0] hold_cnt_r;

    assign timeout_s = (hold_cnt_r == HT_W'(HOLD_TIMEOUT - 1));

    // Hold timer: cleared while not holding, counts every cycle spent in HOLD.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt_r <= {HT_W{1'b0}};
        end else if (state_r != S_HOLD) begin
            hold_cnt_r <= {HT_W{1'b0}};
        end else begin
            hold_cnt_r <= hold_cnt_r + HT_W'(1);
        end
    end
`else
    assign timeout_s = 1'b0;
`endif

    // Move FSM with registered command pulses and game status.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r        <= S_IDLE;
            pick_r         <= 1'b0;
            place_r        <= 1'b0;
            fig_pos_r      <= 6'd0;
            from_pos_r     <= 6'd0;
            holding_r      <= 1'b0;
            turn_r         <= 1'b0;
            move_done_r    <= 1'b0;
            game_over_r    <= 1'b0;
            winner_r       <= 1'b0;
            capture_king_r <= 1'b0;
        end else begin
            pick_r      <= 1'b0;
            place_r     <= 1'b0;
            move_done_r <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    if (event_s && bus.cursor_valid && is_own(bus.sq_code, turn_r)) begin
                        state_r    <= S_PICK;
                        pick_r     <= 1'b1;
                        fig_pos_r  <= bus.cursor_pos;
                        from_pos_r <= bus.cursor_pos;
                    end else begin
                        state_r <= S_IDLE;
                    end
                end
                S_PICK: begin
                    state_r   <= S_HOLD;
                    holding_r <= 1'b1;
                end
                S_HOLD: begin
                    // A click in the timeout cycle wins over the timeout.
                    if (event_s && bus.cursor_valid && (bus.cursor_pos == from_pos_r)) begin
                        state_r   <= S_RET;
                        place_r   <= 1'b1;
                        fig_pos_r <= from_pos_r;
                        holding_r <= 1'b0;
                    end else if (event_s && bus.cursor_valid && legal_s &&
                                 !is_own(bus.sq_code, turn_r)) begin
                        state_r        <= S_PLACE;
                        place_r        <= 1'b1;
                        fig_pos_r      <= bus.cursor_pos;
                        holding_r      <= 1'b0;
                        capture_king_r <= (bus.sq_code == opponent_king(turn_r));
                    end else if (timeout_s) begin
                        state_r   <= S_RET;
                        place_r   <= 1'b1;
                        fig_pos_r <= from_pos_r;
                        holding_r <= 1'b0;
                    end else begin
                        state_r <= S_HOLD;
                    end
                end
                S_PLACE: begin
                    move_done_r <= 1'b1;
                    turn_r      <= ~turn_r;
                    if (capture_king_r) begin
                        game_over_r <= 1'b1;
                        winner_r    <= turn_r;
                        state_r     <= S_OVER;
                    end else begin
                        state_r <= S_IDLE;
                    end
                end
                S_RET: begin
                    state_r <= S_IDLE;
                end
                S_OVER: begin
                    state_r <= S_OVER;
                end
                default: begin
                    state_r   <= S_IDLE;
                    holding_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.pick_piece      = pick_r;
    assign bus.place_piece     = place_r;
    assign bus.figure_position = fig_pos_r;
    assign bus.from_pos        = from_pos_r;
    assign bus.holding         = holding_r;
    assign bus.turn            = turn_r;
    assign bus.move_done       = move_done_r;
    assign bus.game_over       = game_over_r;
    assign bus.winner          = winner_r;

endmodule

// File: tb/tb_move_controller.sv
// tb_move_controller: directed self-checking bench for move_controller
// (DEBOUNCE_CYCLES = 4, HOLD_TIMEOUT = 50). Pulses are tallied by a negedge monitor.
module tb_move_controller;

    localparam int DEB  = 4;
    localparam int HOLD = 50;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    move_controller_if bus();

    move_controller #(
        .DEBOUNCE_CYCLES(DEB),
        .HOLD_TIMEOUT   (HOLD)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.master)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Monitor totals, written only by the monitor process.
    int         pick_tot    = 0;
    int         place_tot   = 0;
    int         done_tot    = 0;
    int         overlap_tot = 0;
    logic [5:0] last_pick   = 6'd0;
    logic [5:0] last_place  = 6'd0;

    // Snapshots taken by the stimulus process.
    int base_pick, base_place, base_done;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Tally command pulses away from the active edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.pick_piece) begin
                pick_tot  = pick_tot + 1;
                last_pick = bus.figure_position;
            end
            if (bus.place_piece) begin
                place_tot  = place_tot + 1;
                last_place = bus.figure_position;
            end
            if (bus.move_done) done_tot = done_tot + 1;
            if (bus.pick_piece && bus.place_piece) overlap_tot = overlap_tot + 1;
        end
    end

    task automatic snap();
        base_pick  = pick_tot;
        base_place = place_tot;
        base_done  = done_tot;
    endtask

    // One click: button high for hold_cyc sampled edges, then released long enough to refilter.
    task automatic press(input logic [5:0] pos, input logic [3:0] code, input logic valid,
                         input int hold_cyc);
        @(posedge clk);
        #1;
        bus.cursor_pos   = pos;
        bus.sq_code      = code;
        bus.cursor_valid = valid;
        bus.click        = 1'b1;
        repeat (hold_cyc) @(posedge clk);
        #1;
        bus.click = 1'b0;
        repeat (9) @(posedge clk);
        #1;
    endtask

    task automatic set_mask_bit(input int sq);
        bus.possible_moves     = 64'h0;
        bus.possible_moves[63 - sq] = 1'b1;
    endtask

    initial begin
        bus.click          = 1'b0;
        bus.cursor_pos     = 6'd0;
        bus.cursor_valid   = 1'b0;
        bus.sq_code        = 4'd0;
        bus.possible_moves = 64'h0;

        repeat (3) @(posedge clk);
        #1;
        // Reset state
        check_eq("rst_pick",    64'(bus.pick_piece),      64'd0);
        check_eq("rst_place",   64'(bus.place_piece),     64'd0);
        check_eq("rst_figpos",  64'(bus.figure_position), 64'd0);
        check_eq("rst_from",    64'(bus.from_pos),        64'd0);
        check_eq("rst_holding", 64'(bus.holding),         64'd0);
        check_eq("rst_turn",    64'(bus.turn),            64'd0);
        check_eq("rst_done",    64'(bus.move_done),       64'd0);
        check_eq("rst_over",    64'(bus.game_over),       64'd0);
        check_eq("rst_winner",  64'(bus.winner),          64'd0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // White to move: a black piece is not pickable
        snap();
        press(6'd10, 4'd7, 1'b1, 6);
        check_eq("wrong_colour_pick", 64'(pick_tot - base_pick), 64'd0);
        check_eq("wrong_colour_hold", 64'(bus.holding),          64'd0);

        // Two-cycle glitch on a white pawn is filtered out
        snap();
        press(6'o60, 4'd1, 1'b1, 2);
        check_eq("glitch_pick", 64'(pick_tot - base_pick), 64'd0);

        // Four-cycle press gives exactly one pick at square 48
        snap();
        press(6'o60, 4'd1, 1'b1, DEB);
        check_eq("pick_count",   64'(pick_tot - base_pick), 64'd1);
        check_eq("pick_pos",     64'(last_pick),            64'd48);
        check_eq("pick_from",    64'(bus.from_pos),         64'd48);
        check_eq("pick_holding", 64'(bus.holding),          64'd1);

        // Legal move to square 40
        set_mask_bit(40);
        snap();
        press(6'o50, 4'd0, 1'b1, 6);
        check_eq("place_count", 64'(place_tot - base_place), 64'd1);
        check_eq("place_pos",   64'(last_place),             64'd40);
        check_eq("move_done",   64'(done_tot - base_done),   64'd1);
        check_eq("turn_black",  64'(bus.turn),               64'd1);
        check_eq("place_hold0", 64'(bus.holding),            64'd0);

        // Black picks a pawn at square 8
        set_mask_bit(16);
        snap();
        press(6'd8, 4'd7, 1'b1, 6);
        check_eq("bpick_count", 64'(pick_tot - base_pick), 64'd1);
        check_eq("bpick_pos",   64'(last_pick),            64'd8);

`ifdef AUTO_RETURN_EN
        // Left untouched: the piece goes back to its origin with no move_done
        snap();
        repeat (60) @(posedge clk);
        #1;
        check_eq("auto_ret_place", 64'(place_tot - base_place), 64'd1);
        check_eq("auto_ret_pos",   64'(last_place),             64'd8);
        check_eq("auto_ret_hold",  64'(bus.holding),            64'd0);
        check_eq("auto_ret_done",  64'(done_tot - base_done),   64'd0);
        check_eq("auto_ret_turn",  64'(bus.turn),               64'd1);
        press(6'd8, 4'd7, 1'b1, 6);
`else
        // Without auto-return a piece stays in hand indefinitely
        snap();
        repeat (60) @(posedge clk);
        #1;
        check_eq("long_hold",       64'(bus.holding),            64'd1);
        check_eq("long_hold_place", 64'(place_tot - base_place), 64'd0);
`endif

        // Mask bit clear: ignored, still holding
        snap();
        press(6'd24, 4'd0, 1'b1, 6);
        check_eq("illegal_pulses", 64'((pick_tot - base_pick) + (place_tot - base_place)), 64'd0);
        check_eq("illegal_hold",   64'(bus.holding), 64'd1);

        // Legal square but cursor outside the board: ignored
        press(6'd16, 4'd0, 1'b0, 6);
        check_eq("invalid_pulses", 64'((pick_tot - base_pick) + (place_tot - base_place)), 64'd0);
        check_eq("invalid_hold",   64'(bus.holding), 64'd1);

        // Click on the origin square cancels the move
        press(6'd8, 4'd7, 1'b1, 6);
        check_eq("cancel_place", 64'(place_tot - base_place), 64'd1);
        check_eq("cancel_pos",   64'(last_place),             64'd8);
        check_eq("cancel_done",  64'(done_tot - base_done),   64'd0);
        check_eq("cancel_turn",  64'(bus.turn),               64'd1);
        check_eq("cancel_hold",  64'(bus.holding),            64'd0);

        // Black queen captures the white king on square 60
        snap();
        press(6'd3, 4'd11, 1'b1, 6);
        check_eq("queen_pick", 64'(last_pick), 64'd3);
        set_mask_bit(60);
        press(6'd60, 4'd6, 1'b1, 6);
        check_eq("capture_place",  64'(last_place),           64'd60);
        check_eq("capture_done",   64'(done_tot - base_done), 64'd1);
        check_eq("capture_over",   64'(bus.game_over),        64'd1);
        check_eq("capture_winner", 64'(bus.winner),           64'd1);
        check_eq("capture_turn",   64'(bus.turn),             64'd0);

        // Game over: further clicks do nothing
        snap();
        press(6'd50, 4'd1, 1'b1, 6);
        press(6'd60, 4'd12, 1'b1, 6);
        check_eq("over_pulses", 64'((pick_tot - base_pick) + (place_tot - base_place)), 64'd0);
        check_eq("over_sticky", 64'(bus.game_over), 64'd1);

        check_eq("no_overlap", 64'(overlap_tot), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
